// File: rtl/sudoku_grid_checker.sv
// Sweeps the four 4x4-grid row words, registers win and duplicate flags.
// Optional CHECKER_STICKY_WIN_EN: gameComplete latches until reset.
module sudoku_grid_checker #(
  parameter int SCAN_GAP = 8,
  parameter int DATA_W   = 20
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [1:0]        RamAddr,
  input  logic [DATA_W-1:0] RamDat,
  output logic              gameComplete,
  output logic              conflict,
  output logic              sweepDone
);

  typedef enum logic [1:0] {
    GAP,
    FETCH,
    CAPT,
    EVAL
  } state_t;

  localparam logic [7:0] GAP_LD = SCAN_GAP[7:0];

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_gap;
  logic [7:0]  w_gap_nxt;
  logic [1:0]  r_addr;
  logic [1:0]  w_addr_nxt;
  logic [15:0] r_row [4];
  logic        w_capt;
  logic [1:0]  w_capt_idx;
  logic        r_done;
  logic        r_gc;
  logic        r_cf;
  logic [3:0]  w_cell [16];
  logic        w_dup;
  logic        w_full;
  logic        w_unused_wp;

  // Write-protect flags ride along in the word but do not matter here.
  assign w_unused_wp = ^RamDat[DATA_W-1:16];

  function automatic logic f_dup(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [3:0] c,
    input logic [3:0] d
  );
    return (a != 4'd0 && (a == b || a == c || a == d)) ||
           (b != 4'd0 && (b == c || b == d)) ||
           (c != 4'd0 && c == d);
  endfunction

  function automatic logic [3:0] f_set(input logic [3:0] v);
    logic [3:0] s;
    s = 4'b0000;
    case (v)
      4'd1:    s = 4'b0001;
      4'd2:    s = 4'b0010;
      4'd3:    s = 4'b0100;
      4'd4:    s = 4'b1000;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Four cells covering all of 1..4 also rules out empty or illegal cells.
  function automatic logic f_full(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [3:0] c,
    input logic [3:0] d
  );
    return (f_set(a) | f_set(b) | f_set(c) | f_set(d)) == 4'hf;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_addr_nxt  = r_addr;
    w_capt      = 1'b0;
    w_capt_idx  = r_addr - 2'd1;
    unique case (r_state)
      GAP: begin
        w_addr_nxt = 2'd0;
        if (r_gap == 8'd0) begin
          w_state_nxt = FETCH;
        end else begin
          w_gap_nxt = r_gap - 8'd1;
        end
      end
      FETCH: begin
        w_capt = (r_addr != 2'd0);
        if (r_addr == 2'd3) begin
          w_addr_nxt  = 2'd0;
          w_state_nxt = CAPT;
        end else begin
          w_addr_nxt = r_addr + 2'd1;
        end
      end
      CAPT: begin
        w_capt      = 1'b1;
        w_capt_idx  = 2'd3;
        w_addr_nxt  = 2'd0;
        w_state_nxt = EVAL;
      end
      EVAL: begin
        w_gap_nxt   = GAP_LD;
        w_state_nxt = GAP;
      end
      default: begin
        w_state_nxt = GAP;
      end
    endcase
  end

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_cell[r*4+c] = r_row[r][c*4 +: 4];
      end
    end
  end

  // Row g, column g and box g are checked side by side.
  always_comb begin
    w_dup  = 1'b0;
    w_full = 1'b1;
    for (int g = 0; g < 4; g++) begin
      w_dup = w_dup |
        f_dup(w_cell[g*4], w_cell[g*4+1],
              w_cell[g*4+2], w_cell[g*4+3]) |
        f_dup(w_cell[g], w_cell[g+4],
              w_cell[g+8], w_cell[g+12]) |
        f_dup(w_cell[(g/2)*8+(g%2)*2],
              w_cell[(g/2)*8+(g%2)*2+1],
              w_cell[(g/2)*8+(g%2)*2+4],
              w_cell[(g/2)*8+(g%2)*2+5]);
      w_full = w_full &
        f_full(w_cell[g*4], w_cell[g*4+1],
               w_cell[g*4+2], w_cell[g*4+3]) &
        f_full(w_cell[g], w_cell[g+4],
               w_cell[g+8], w_cell[g+12]) &
        f_full(w_cell[(g/2)*8+(g%2)*2],
               w_cell[(g/2)*8+(g%2)*2+1],
               w_cell[(g/2)*8+(g%2)*2+4],
               w_cell[(g/2)*8+(g%2)*2+5]);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= GAP;
      r_gap   <= GAP_LD;
      r_addr  <= 2'd0;
      r_done  <= 1'b0;
      r_gc    <= 1'b0;
      r_cf    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_row[i] <= 16'd0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      r_addr  <= w_addr_nxt;
      r_done  <= (w_state_nxt == EVAL);
      if (w_capt) begin
        r_row[w_capt_idx] <= RamDat[15:0];
      end
      if (r_state == EVAL) begin
        r_cf <= w_dup;
`ifdef CHECKER_STICKY_WIN_EN
        r_gc <= r_gc | w_full;
`else
        r_gc <= w_full;
`endif
      end
    end
  end

  assign RamAddr      = r_addr;
  assign sweepDone    = r_done;
  assign gameComplete = r_gc;
  assign conflict     = r_cf;

endmodule

// File: doc/sudoku_grid_checker.md
Name: sudoku_grid_checker

Overview:
- Downstream consumer of the sudoku RAM's read-only port B.
- Continuously sweeps the four 4x4-grid row words and registers whether the board is a legal completed solution. It also reports whether any duplicate is currently present.
- Drives the top-level win indicator and gates the game timer's reconfigure input.
- Contains no write path to RAM.

Parameters:
- SCAN_GAP, 8: idle cycles between the end of one sweep and the start of the next. Legal range 0..255.
- DATA_W, 20: RAM word width. Bits [15:0] hold the four cells; bits [19:16] are write-protect flags and are ignored by this block.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- RST  in  1  asynchronous, active-low reset
- RamAddr  out  2  RAM port-B row address
- RamDat  in  DATA_W  RAM port-B read data, valid one cycle after RamAddr
- gameComplete  out  1  registered: grid is a full legal solution
- conflict  out  1  registered: at least one duplicate nonzero value in a row, column or 2x2 box
- sweepDone  out  1  one-cycle pulse when gameComplete and conflict are refreshed

Behaviour:
- Cell layout: cell c of a row word = RamDat[4c+3:4c], c=0..3; column 0 is the lowest nibble. Value 0 = empty; legal values 1..4; 5..15 = illegal.
- Boxes: rows {0,1}/{2,3} crossed with columns {0,1}/{2,3}.
- Reset (RST low, asynchronous): state=GAP, gap counter=SCAN_GAP, RamAddr=0, row registers=0, gameComplete=0, conflict=0, sweepDone=0.
- FSM states: GAP, FETCH, CAPT, EVAL.
- GAP:
  - Gap counter decrements each cycle; RamAddr held at 0.
  - When the counter reads 0: go to FETCH, RamAddr=0.
  - With SCAN_GAP=0, GAP lasts exactly one cycle.
- FETCH:
  - Four cycles; RamAddr presents 0,1,2,3.
  - Each cycle after the first, the row register for the previous address captures RamDat.
  - After address 3: go to CAPT.
- CAPT: one cycle; captures row 3; RamAddr returns to 0; go to EVAL.
- EVAL: one cycle.
  - Combinational check over the 16 captured cells; results registered at the end of the cycle.
  - sweepDone=1 for this cycle only.
  - Gap counter reloads SCAN_GAP; go to GAP.
- Sweep period: 4+1+1 cycles plus the GAP length.
  - First sweepDone after reset deassertion: cycle SCAN_GAP+7.
  - Count the cycle in which RST rises as cycle 1.
- gameComplete=1 only if all of the following hold:
  - all 16 cells are in 1..4;
  - every row contains {1,2,3,4};
  - every column contains {1,2,3,4};
  - every box contains {1,2,3,4}.
- conflict=1 if any two equal nonzero cells share a row, column or box. Illegal values 5..15 participate in duplicate detection.
- A full grid containing any illegal value gives gameComplete=0, whatever conflict reports.
- Outputs change only at the end of EVAL; they are stable for the whole sweep.
- RAM writes via port A during a sweep:
  - Each row is sampled once per sweep.
  - A mixed old/new snapshot is allowed; the next sweep corrects it.
- Reset mid-sweep: immediate return to reset values; partial row data is discarded.

Optional Feature:
- Macro: CHECKER_STICKY_WIN_EN.
- Defined:
  - Once gameComplete is registered as 1, it holds 1 until RST.
  - Sweeps continue and conflict still updates.
  - Prevents the timer restarting if the user edits a solved board.
- Undefined: gameComplete is recomputed every EVAL and may fall back to 0.

Test Plan:
- Solved grid, SCAN_GAP=8. Rows: 20'h04321, 20'h02143, 20'h03412, 20'h01234.
  -> sweepDone at cycle 15 after reset release; gameComplete=1, conflict=0.
- All-zero RAM -> every sweepDone shows gameComplete=0, conflict=0. RamAddr sequence per sweep: 0,1,2,3 then 0.
- Solved grid with row 2 changed to 20'h03413 (duplicate 3 in row, column and box)
  -> gameComplete=0, conflict=1.
- Solved grid with row 0 cell 0 set to 5 (20'h04325) -> gameComplete=0, conflict=0.
- Solved grid, then port-A write of 20'h00000 to row 1 during GAP.
  -> next sweep: gameComplete 1->0 without the macro; stays 1 with CHECKER_STICKY_WIN_EN.
- Assert RST during FETCH (RamAddr=2).
  -> all outputs 0 asynchronously; after release, the next sweepDone arrives at cycle SCAN_GAP+7 with correct results.
